// File: rtl/mem_access_stage_pkg.sv
// Shared types and constants for the MEM-stage data-memory access unit.
// Holds the FSM encoding, WB control bit positions and timeout defaults.
package mem_access_stage_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int WB_MEMTOREG     = 0;
    localparam int WB_REGWRITE     = 1;

    localparam int DEFAULT_TIMEOUT = 16;
    localparam int DEFAULT_CNT_W   = 8;

    function automatic logic [31:0] word_addr(input logic [31:0] byte_addr);
        return byte_addr & 32'hFFFF_FFFC;
    endfunction

    // A failed access must never commit to the register file.
    function automatic logic [1:0] kill_regwrite(input logic [1:0] wb);
        logic [1:0] res;
        res              = wb;
        res[WB_REGWRITE] = 1'b0;
        return res;
    endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory port between the MEM stage (master) and the memory (slave).
// Signal names keep the stage-side port names so traces line up with the pipeline.
interface mem_access_stage_if;

    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;

    modport master (
        output mem_req_o,
        output mem_we_o,
        output mem_addr_o,
        output mem_wdata_o,
        input  mem_ack_i,
        input  mem_rdata_i
    );

    modport slave (
        input  mem_req_o,
        input  mem_we_o,
        input  mem_addr_o,
        input  mem_wdata_o,
        output mem_ack_i,
        output mem_rdata_i
    );

endinterface

// File: rtl/mem_timeout_ctr.sv
// Cycle counter bounding how long an access may wait for the memory ack.
// expired is high while the count sits at TIMEOUT-1, i.e. in the last allowed wait cycle.
module mem_timeout_ctr #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i || clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign expired = (cnt == LAST);

endmodule

// File: rtl/mem_access_stage.sv
// MEM-stage access unit: turns MemRead/MemWrite into a req/ack memory transaction,
// stalls upstream until it completes and flags misaligned or timed-out accesses.
//
// state | meaning
// IDLE  | no transaction; aligned access raises stall and launches, misaligned pulses err
// BUSY  | mem_req_o held high waiting for ack; aborts after TIMEOUT cycles
// DONE  | result presented to MEM/WB, upstream released; always returns to IDLE
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int CNT_W   = DEFAULT_CNT_W
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [1:0]  WB_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  rd_i,

    mem_access_stage_if.master mem,

    output logic [1:0]  WB_o,
    output logic [31:0] addr_o,
    output logic [31:0] data_o,
    output logic [4:0]  rd_o,
    output logic        stall_o,
    output logic        err_o
);

    state_t      state_q;
    state_t      state_d;
    logic [31:0] rdata_q;
    logic        err_q;

    logic        access;
    logic        misaligned;
    logic        ctr_clear;
    logic        ctr_en;
    logic        ctr_expired;

    assign access     = MemRead_i | MemWrite_i;
    assign misaligned = access & (addr_i[1:0] != 2'b00);

    // EX/MEM is frozen while stalled, so the request fields can come straight from it.
    assign mem.mem_we_o    = MemWrite_i;
    assign mem.mem_addr_o  = word_addr(addr_i);
    assign mem.mem_wdata_o = wdata_i;

    assign addr_o = addr_i;
    assign rd_o   = rd_i;

    mem_timeout_ctr #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_timeout_ctr (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear   (ctr_clear),
        .enable  (ctr_en),
        .expired (ctr_expired)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_BUSY) begin
                if (mem.mem_ack_i) begin
                    rdata_q <= MemWrite_i ? 32'h0 : mem.mem_rdata_i;
                    err_q   <= 1'b0;
                end else if (ctr_expired) begin
                    rdata_q <= '0;
                    err_q   <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        mem.mem_req_o = 1'b0;
        stall_o       = 1'b0;
        err_o         = 1'b0;
        WB_o          = WB_i;
        data_o        = '0;
        ctr_clear     = 1'b0;
        ctr_en        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (misaligned) begin
                    err_o = 1'b1;
                    WB_o  = kill_regwrite(WB_i);
                end else if (access) begin
                    stall_o   = 1'b1;
                    ctr_clear = 1'b1;
                    state_d   = ST_BUSY;
                end
            end

            ST_BUSY: begin
                mem.mem_req_o = 1'b1;
                stall_o       = 1'b1;
                // An ack in the final wait cycle still completes the access normally.
                if (mem.mem_ack_i) begin
                    state_d = ST_DONE;
                end else if (ctr_expired) begin
                    state_d = ST_DONE;
                end else begin
                    ctr_en = 1'b1;
                end
            end

            ST_DONE: begin
                data_o  = rdata_q;
                err_o   = err_q;
                if (err_q) begin
                    WB_o = kill_regwrite(WB_i);
                end
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
MEM-stage data-memory access unit between the EX/MEM and MEM/WB pipeline registers.
- Turns MemRead/MemWrite control into a req/ack transaction on a variable-latency data-memory port.
- Stalls the upstream pipeline until the access completes.
- Presents load data, ALU address, rd and WB controls for the MEM/WB register to latch.
- Detects misaligned accesses and memory timeouts.

Parameters:
TIMEOUT, 16, maximum BUSY cycles to wait for mem_ack_i before aborting (2..255)
CNT_W, 8, width of the timeout counter

Ports:
clk_i  input  1  clock; all state updates on its rising edge
rst_i  input  1  synchronous active-high reset
MemRead_i  input  1  load request from EX/MEM
MemWrite_i  input  1  store request from EX/MEM
WB_i  input  2  WB controls from EX/MEM; [0]=MemtoReg, [1]=RegWrite
addr_i  input  32  ALU result / byte address from EX/MEM
wdata_i  input  32  store data from EX/MEM
rd_i  input  5  destination register from EX/MEM
mem_req_o  output  1  memory request, held high until ack
mem_we_o  output  1  1=write, 0=read; valid while mem_req_o=1
mem_addr_o  output  32  word address {addr_i[31:2],2'b00}
mem_wdata_o  output  32  store data
mem_ack_i  input  1  memory completion, single-cycle pulse
mem_rdata_i  input  32  read data, valid with mem_ack_i
WB_o  output  2  WB controls to MEM/WB; RegWrite forced 0 on error
addr_o  output  32  addr_i passthrough
data_o  output  32  load data to MEM/WB
rd_o  output  5  rd_i passthrough
stall_o  output  1  freeze PC, IF/ID, ID/EX and EX/MEM; bubble is not inserted by this block
err_o  output  1  one-cycle pulse on misaligned access or timeout

Behaviour:
- Definitions: access = MemRead_i|MemWrite_i. misaligned = access & (addr_i[1:0]!=0). Both asserted together is treated as a write.
- FSM states: IDLE, BUSY, DONE. Registers: state, cnt[CNT_W], rdata_q[32], err_q.
- Reset (rst_i=1 at an edge):
  - state=IDLE, cnt=0, rdata_q=0, err_q=0.
  - mem_req_o=0, stall_o=0, err_o=0.
  - data_o reads 0 after reset. Passthrough outputs follow their inputs.
- IDLE:
  - mem_req_o=0.
  - If access & !misaligned: stall_o=1 combinationally this cycle; next state BUSY, cnt=0.
  - If misaligned: no stall, no request, err_o=1 this cycle, WB_o={1'b0,WB_i[0]}; stay IDLE.
  - If no access: stall_o=0, data_o=0; stay IDLE.
  - mem_ack_i is ignored in IDLE and DONE (late ack after reset or timeout).
- BUSY:
  - mem_req_o=1, mem_we_o=MemWrite_i, address and data are driven from the held EX/MEM inputs; stall_o=1.
  - On mem_ack_i: rdata_q<=mem_rdata_i for reads, 0 for writes; err_q<=0; next state DONE.
  - Else if cnt==TIMEOUT-1: rdata_q<=0, err_q<=1; next state DONE.
  - Else cnt<=cnt+1.
  - Ack wins over timeout in the same cycle.
- DONE:
  - stall_o=0, mem_req_o=0, data_o=rdata_q, err_o=err_q.
  - If err_q=1, WB_o[1]=0.
  - MEM/WB latches at the end of DONE while upstream advances. Next state is IDLE unconditionally; no new access starts in DONE.
- Latency: an aligned access stalls from its first IDLE cycle through the ack cycle. Minimum 2 stall cycles (ack in first BUSY cycle); completion is in the cycle after ack.
- Outside DONE, WB_o=WB_i except in the misaligned case above.
- rst_i during BUSY: mem_req_o drops at the following cycle and the transaction is abandoned. The memory must tolerate request withdrawal.

Decomposition:
- Shared package:
  - FSM state encoding.
  - WB bit indices: WB_MEMTOREG=0, WB_REGWRITE=1.
  - Default TIMEOUT.
- Sub-module: mem_timeout_ctr (clear/enable/expired counter, parameterised by TIMEOUT and CNT_W).

Test Plan:
- Load, addr_i=0x00000010, ack with rdata=0xDEADBEEF on 3rd BUSY cycle -> stall_o high 4 cycles, mem_addr_o=0x10, we=0; in DONE data_o=0xDEADBEEF, stall_o=0, WB_o=2'b11.
- Store, addr_i=0x24, wdata=0x12345678, ack in first BUSY cycle -> mem_we_o=1, mem_wdata_o=0x12345678, stall_o high exactly 2 cycles, data_o=0 in DONE, err_o=0.
- Load at addr_i=0x13 -> no mem_req_o, stall_o=0, err_o pulse 1 cycle, WB_o=2'b01.
- Load, never acked, TIMEOUT=16 -> stall 17 cycles, DONE with err_o=1, WB_o[1]=0, data_o=0; ack arriving one cycle later is ignored.
- rst_i asserted in 2nd BUSY cycle -> next cycle mem_req_o=0, stall_o=0, state IDLE; subsequent ack has no effect.
- Load, ALU op, load back-to-back (acks after 1 cycle) -> ALU op passes with stall_o=0, data_o=0; each load produces an independent DONE with the correct data.
